// File: rtl/spec_ghr_ckpt.sv
// Speculative global history register with per-branch checkpoints.
// One-cycle restore on mispredict or flush; gshare index generation.
module spec_ghr_ckpt #(
    parameter int GHR_WIDTH  = 8,
    parameter int CKPT_DEPTH = 8,
    parameter int IDX_W      = 8,
    localparam int TAG_W     = $clog2(CKPT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic                 if_taken,
    input  logic [31:0]          if_pc,
    output logic                 if_ready,
    output logic [TAG_W-1:0]     if_tag,
    output logic [IDX_W-1:0]     pht_idx,
    input  logic                 ex_valid,
    input  logic [TAG_W-1:0]     ex_tag,
    input  logic                 ex_taken,
    input  logic                 ex_mispredict,
    input  logic                 flush,
    output logic [GHR_WIDTH-1:0] spec_ghr,
    output logic [GHR_WIDTH-1:0] arch_ghr,
    output logic [TAG_W:0]       ckpt_cnt,
    output logic                 tag_err
);

    localparam int NSL = (GHR_WIDTH + IDX_W - 1) / IDX_W;
    localparam logic [TAG_W:0]   L_FULL = (TAG_W + 1)'(CKPT_DEPTH);
    localparam logic [TAG_W:0]   L_CONE = (TAG_W + 1)'(1);
    localparam logic [TAG_W-1:0] L_ONE  = TAG_W'(1);

    logic [GHR_WIDTH-1:0] r_spec;
    logic [GHR_WIDTH-1:0] r_arch;
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_cnt;
    logic                 r_tag_err;
    logic [GHR_WIDTH-1:0] r_ckpt [CKPT_DEPTH];

    logic                 w_empty;
    logic                 w_resolve;
    logic                 w_mis;
    logic                 w_ok;
    logic                 w_push;
    logic                 w_terr_set;
    logic [TAG_W:0]       w_cnt_nxt;
    logic [GHR_WIDTH-1:0] w_head_ckpt;
    logic [NSL*IDX_W-1:0] w_pad;
    logic [IDX_W-1:0]     w_fold;

    assign w_empty     = (r_cnt == '0);
    assign w_resolve   = ex_valid && !flush && !w_empty;
    assign w_mis       = w_resolve && ex_mispredict;
    assign w_ok        = w_resolve && !ex_mispredict;
    assign w_head_ckpt = r_ckpt[r_head];

    // A full buffer still accepts a push when the head retires the same cycle.
    assign w_push = if_valid && (if_ready || w_ok) && !flush && !w_mis;

    assign w_terr_set = ex_valid && !flush && (w_empty || ex_tag != r_head);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_ok) begin
            w_cnt_nxt = r_cnt + L_CONE;
        end else if (!w_push && w_ok) begin
            w_cnt_nxt = r_cnt - L_CONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec    <= '0;
            r_arch    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_cnt     <= '0;
            r_tag_err <= 1'b0;
        end else begin
            if (w_terr_set) begin
                r_tag_err <= 1'b1;
            end
            if (flush) begin
                r_spec <= r_arch;
                r_head <= '0;
                r_tail <= '0;
                r_cnt  <= '0;
            end else if (w_mis) begin
                // Everything younger than head is wrong-path: drop it all.
                r_spec <= {w_head_ckpt[GHR_WIDTH-2:0], ex_taken};
                r_arch <= {r_arch[GHR_WIDTH-2:0], ex_taken};
                r_head <= r_head + L_ONE;
                r_tail <= r_head + L_ONE;
                r_cnt  <= '0;
            end else begin
                if (w_push) begin
                    r_spec <= {r_spec[GHR_WIDTH-2:0], if_taken};
                    r_tail <= r_tail + L_ONE;
                end
                if (w_ok) begin
                    r_arch <= {r_arch[GHR_WIDTH-2:0], ex_taken};
                    r_head <= r_head + L_ONE;
                end
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ckpt[r_tail] <= r_spec;
        end
    end

    always_comb begin
        w_pad = '0;
        w_pad[GHR_WIDTH-1:0] = r_spec;
        w_fold = '0;
        for (int i = 0; i < NSL; i++) begin
            w_fold = w_fold ^ w_pad[i*IDX_W +: IDX_W];
        end
    end

    assign pht_idx  = if_pc[IDX_W+1:2] ^ w_fold;
    assign if_ready = (r_cnt != L_FULL);
    assign if_tag   = r_tail;
    assign spec_ghr = r_spec;
    assign arch_ghr = r_arch;
    assign ckpt_cnt = r_cnt;
    assign tag_err  = r_tag_err;

endmodule

// File: tb/tb_spec_ghr_ckpt.sv
// Vector-table bench for spec_ghr_ckpt (GHR=8, DEPTH=8, IDX=8).
// Expected state per cycle is queued at drive time and popped after the edge.
module tb_spec_ghr_ckpt;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_taken, ex_valid, ex_taken, ex_mispredict, flush;
    logic [31:0] if_pc;
    logic [2:0]  ex_tag;
    logic        if_ready, tag_err;
    logic [2:0]  if_tag;
    logic [7:0]  pht_idx, spec_ghr, arch_ghr;
    logic [3:0]  ckpt_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spec_ghr_ckpt dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_taken(if_taken), .if_pc(if_pc),
        .if_ready(if_ready), .if_tag(if_tag), .pht_idx(pht_idx),
        .ex_valid(ex_valid), .ex_tag(ex_tag), .ex_taken(ex_taken),
        .ex_mispredict(ex_mispredict), .flush(flush),
        .spec_ghr(spec_ghr), .arch_ghr(arch_ghr),
        .ckpt_cnt(ckpt_cnt), .tag_err(tag_err)
    );

    typedef struct {
        logic        rst, iv, it, ev;
        logic [2:0]  etg;
        logic        et, em, fl;
        logic [31:0] pc;
        logic [7:0]  spec, arch;
        logic [3:0]  cnt;
        logic        rdy, terr;
        logic [2:0]  tag;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    localparam logic [31:0] P  = 32'h0000_1234;
    localparam logic [31:0] PC = 32'h1C00_0010;

    function automatic vec_t v(
        input logic rs, iv, it, ev, input logic [2:0] etg,
        input logic et, em, fl, input logic [31:0] pc,
        input logic [7:0] sp, ar, input logic [3:0] cn,
        input logic rd, te, input logic [2:0] tg);
        vec_t r;
        r.rst = rs; r.iv = iv; r.it = it; r.ev = ev; r.etg = etg;
        r.et = et; r.em = em; r.fl = fl; r.pc = pc;
        r.spec = sp; r.arch = ar; r.cnt = cn;
        r.rdy = rd; r.terr = te; r.tag = tg;
        return r;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; if_valid = x.iv; if_taken = x.it;
        ex_valid = x.ev; ex_tag = x.etg; ex_taken = x.et;
        ex_mispredict = x.em; flush = x.fl; if_pc = x.pc;
    endtask

    task automatic step(input vec_t x, input int id);
        vec_t e;
        drive(x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        ex_valid = 1'b0; if_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        if (exp_q.size() == 0) begin
            chk("queue_empty", id, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("spec_ghr", id, 32'(spec_ghr), 32'(e.spec));
            chk("arch_ghr", id, 32'(arch_ghr), 32'(e.arch));
            chk("ckpt_cnt", id, 32'(ckpt_cnt), 32'(e.cnt));
            chk("if_ready", id, 32'(if_ready), 32'(e.rdy));
            chk("tag_err",  id, 32'(tag_err),  32'(e.terr));
            chk("if_tag",   id, 32'(if_tag),   32'(e.tag));
            chk("pht_idx",  id, 32'(pht_idx),  32'(e.pc[9:2] ^ e.spec));
        end
    endtask

    function automatic vec_t rv();
        return v(1,0,0,0,0,0,0,0,P, 8'h00,8'h00,0,1,0,0);
    endfunction

    initial begin
        logic [7:0] s;
        logic [7:0] pat;
        logic [7:0] m;
        logic       d;
        drive(rv());
        // reset
        tbl.push_back(rv());
        tbl.push_back(rv());
        // push T,T,N then resolve in order
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h01,8'h00,1,1,0,1));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h03,8'h00,2,1,0,2));
        tbl.push_back(v(0,1,0,0,0,0,0,0,P, 8'h06,8'h00,3,1,0,3));
        tbl.push_back(v(0,0,0,1,0,1,0,0,P, 8'h06,8'h01,2,1,0,3));
        tbl.push_back(v(0,0,0,1,1,1,0,0,P, 8'h06,8'h03,1,1,0,3));
        tbl.push_back(v(0,0,0,1,2,0,0,0,P, 8'h06,8'h06,0,1,0,3));
        // mispredict on oldest with same-cycle push dropped
        tbl.push_back(rv());
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h01,8'h00,1,1,0,1));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h03,8'h00,2,1,0,2));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h07,8'h00,3,1,0,3));
        tbl.push_back(v(0,1,1,1,0,0,1,0,P, 8'h00,8'h00,0,1,0,1));
        tbl.push_back(v(0,1,0,0,0,0,0,0,P, 8'h00,8'h00,1,1,0,2));
        // fill, overflow push, push+resolve when full
        tbl.push_back(rv());
        s = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            s = {s[6:0], 1'b1};
            tbl.push_back(v(0,1,1,0,0,0,0,0,P, s,8'h00,4'(i),
                            (i < 8),0,3'(i)));
        end
        tbl.push_back(v(0,1,0,0,0,0,0,0,P, 8'hFF,8'h00,8,0,0,0));
        tbl.push_back(v(0,1,0,1,0,1,0,0,P, 8'hFE,8'h01,8,0,0,1));
        // flush restores committed history
        tbl.push_back(rv());
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h01,8'h00,1,1,0,1));
        tbl.push_back(v(0,1,0,0,0,0,0,0,P, 8'h02,8'h00,2,1,0,2));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h05,8'h00,3,1,0,3));
        tbl.push_back(v(0,0,0,1,0,1,0,0,P, 8'h05,8'h01,2,1,0,3));
        tbl.push_back(v(0,0,0,1,1,0,0,0,P, 8'h05,8'h02,1,1,0,3));
        tbl.push_back(v(0,0,0,1,2,1,0,0,P, 8'h05,8'h05,0,1,0,3));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h0B,8'h05,1,1,0,4));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h17,8'h05,2,1,0,5));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h2F,8'h05,3,1,0,6));
        tbl.push_back(v(0,1,1,1,3,1,0,1,P, 8'h05,8'h05,0,1,0,0));
        // resolve while empty: sticky tag_err
        tbl.push_back(v(0,0,0,1,0,1,0,0,P, 8'h05,8'h05,0,1,1,0));
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h0B,8'h05,1,1,1,1));
        // push while empty plus resolve
        tbl.push_back(rv());
        tbl.push_back(v(0,1,1,1,0,1,0,0,P, 8'h01,8'h00,1,1,1,1));
        // tag mismatch still retires
        tbl.push_back(rv());
        tbl.push_back(v(0,1,1,0,0,0,0,0,P, 8'h01,8'h00,1,1,0,1));
        tbl.push_back(v(0,0,0,1,1,1,0,0,P, 8'h01,8'h01,0,1,1,1));
        // build spec_ghr=0xA5 for the gshare index
        tbl.push_back(rv());
        pat = 8'hA5;
        s = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            s = {s[6:0], pat[8-i]};
            tbl.push_back(v(0,1,pat[8-i],0,0,0,0,0,PC, s,8'h00,4'(i),
                            (i < 8),0,3'(i)));
        end

        @(negedge clk);
        foreach (tbl[i]) step(tbl[i], i);
        if_pc = PC;
        #1;
        chk("pht_idx_A1", 999, 32'(pht_idx), 32'h0000_00A1);

        // random directions after reset against a shift model
        step(rv(), 1000);
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = 1'($urandom_range(0, 1));
            m = {m[6:0], d};
            drive(v(0,1,d,0,0,0,0,0,P, 0,0,0,0,0,0));
            @(posedge clk);
            #1;
            if_valid = 1'b0;
            chk("rand_spec", 1001 + i, 32'(spec_ghr), 32'(m));
        end
        chk("rand_full", 1009, 32'(if_ready), 32'd0);
        drive(v(0,1,~m[0],0,0,0,0,0,P, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        chk("rand_hold", 1010, 32'(spec_ghr), 32'(m));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
